// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues word reads over req/ready and
// presents one instruction at a time downstream, with redirect/squash support.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        fetch_fault
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    S_BOOT    = 3'd0,
    S_FETCH   = 3'd1,
    S_HOLD    = 3'd2,
    S_DISCARD = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  state_t            r_state, w_state;
  logic [XLEN-1:0]   r_pc, w_pc;
  logic [XLEN-1:0]   r_addr, w_addr;
  logic              r_req, w_req;
  logic [XLEN-1:0]   r_instr, w_instr;
  logic [XLEN-1:0]   r_pc_out, w_pc_out;
  logic              r_valid, w_valid;
  logic              r_fault, w_fault;
  logic              w_redir;
  logic              w_misalign;
  logic [XLEN-1:0]   w_redir_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_BOOT;
      r_pc     <= RESET_PC;
      r_addr   <= RESET_PC;
      r_req    <= 1'b0;
      r_instr  <= NOP_INSTR;
      r_pc_out <= '0;
      r_valid  <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_pc     <= w_pc;
      r_addr   <= w_addr;
      r_req    <= w_req;
      r_instr  <= w_instr;
      r_pc_out <= w_pc_out;
      r_valid  <= w_valid;
      r_fault  <= w_fault;
    end
  end

  // Redirect overrides PC/output updates; state transition decided per state.
  always_comb begin
    w_state    = r_state;
    w_pc       = r_pc;
    w_instr    = r_instr;
    w_pc_out   = r_pc_out;
    w_valid    = r_valid;
    w_fault    = r_fault;
    w_redir    = redirect_valid && (r_state != S_BOOT);
    w_misalign = |redirect_pc[1:0];
    w_redir_pc = {redirect_pc[XLEN-1:2], 2'b00};

    if (w_redir) begin
      w_pc    = w_redir_pc;
      w_valid = 1'b0;
      w_instr = NOP_INSTR;
      w_fault = w_misalign;
    end

    case (r_state)
      S_BOOT: w_state = S_FETCH;
      S_FETCH: begin
        if (w_redir) begin
          if (imem_ready) w_state = w_misalign ? S_FAULT : S_FETCH;
          else            w_state = S_DISCARD;
        end else if (imem_ready) begin
          w_instr  = imem_rdata;
          w_pc_out = r_pc;
          w_valid  = 1'b1;
          w_pc     = r_pc + XLEN'(4);
          w_state  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_redir) begin
          w_state = w_misalign ? S_FAULT : S_FETCH;
        end else if (r_valid && instr_ready) begin
          w_valid = 1'b0;
          w_state = S_FETCH;
        end
      end
      S_DISCARD: begin
        if (imem_ready) w_state = w_fault ? S_FAULT : S_FETCH;
      end
      S_FAULT: begin
        if (w_redir) w_state = w_misalign ? S_FAULT : S_FETCH;
      end
      default: w_state = S_BOOT;
    endcase

    // An outstanding request keeps its original address until memory answers.
    w_req  = (w_state == S_FETCH) || (w_state == S_DISCARD);
    w_addr = (w_state == S_DISCARD) ? r_addr : w_pc;
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign instruction = r_instr;
  assign pc_out      = r_pc_out;
  assign instr_valid = r_valid;
  assign fetch_fault = r_fault;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch (RESET_PC = 0x100).
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  instr_fetch #(.RESET_PC(32'h0000_0100), .NOP_INSTR(NOP)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instruction    (instruction),
    .pc_out         (pc_out),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
    tick(); tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b exp 0", imem_req); end
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL reset_addr got %h exp 00000100", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", instr_valid); end
    checks++; if (instruction !== NOP) begin errors++; $display("FAIL reset_instr got %h exp %h", instruction, NOP); end
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc_out got %h exp 0", pc_out); end
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %0b exp 0", fetch_fault); end
    rst_n = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL boot_first_req got req=%0b addr=%h exp req=1 addr=00000100", imem_req, imem_addr); end
  endtask

  task automatic test_stream();
    int nvalid = 0;
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 + 32'(4*i)) begin errors++; $display("FAIL stream_addr%0d got req=%0b addr=%h exp req=1 addr=%h", i, imem_req, imem_addr, 32'h100 + 32'(4*i)); end
      imem_ready = 1'b1; imem_rdata = 32'hA000_0000 + 32'(i);
      tick();
      imem_ready = 1'b0;
      if (instr_valid === 1'b1) nvalid++;
      checks++; if (instruction !== 32'hA000_0000 + 32'(i)) begin errors++; $display("FAIL stream_instr%0d got %h exp %h", i, instruction, 32'hA000_0000 + 32'(i)); end
      checks++; if (pc_out !== 32'h100 + 32'(4*i)) begin errors++; $display("FAIL stream_pc_out%0d got %h exp %h", i, pc_out, 32'h100 + 32'(4*i)); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stream_req_hold%0d got %0b exp 0", i, imem_req); end
      tick();
      if (instr_valid === 1'b1) nvalid++;
    end
    checks++; if (nvalid != 3) begin errors++; $display("FAIL stream_valid_count got %0d exp 3", nvalid); end
  endtask

  task automatic test_hold();
    instr_ready = 1'b0;
    imem_ready = 1'b1; imem_rdata = 32'h0000_B0B0;
    tick();
    imem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (instr_valid !== 1'b1 || instruction !== 32'h0000_B0B0 || pc_out !== 32'h10C || imem_req !== 1'b0) begin
        errors++; $display("FAIL hold_stable%0d got v=%0b instr=%h pc=%h req=%0b exp v=1 instr=0000b0b0 pc=0000010c req=0", i, instr_valid, instruction, pc_out, imem_req);
      end
      tick();
    end
    instr_ready = 1'b1;
    tick();
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h110) begin
      errors++; $display("FAIL hold_release got v=%0b req=%0b addr=%h exp v=0 req=1 addr=00000110", instr_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_outstanding();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h110) begin errors++; $display("FAIL discard_held got req=%0b addr=%h exp req=1 addr=00000110", imem_req, imem_addr); end
    tick(); tick();
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ready = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL discard_valid got %0b exp 0", instr_valid); end
    checks++; if (instruction !== NOP) begin errors++; $display("FAIL discard_instr got %h exp %h", instruction, NOP); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL discard_next got req=%0b addr=%h exp req=1 addr=00000200", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_same_cycle();
    imem_ready = 1'b1; imem_rdata = 32'h1234_5678;
    redirect_valid = 1'b1; redirect_pc = 32'h400;
    tick();
    imem_ready = 1'b0; redirect_valid = 1'b0;
    checks++; if (instr_valid !== 1'b0 || instruction !== NOP) begin errors++; $display("FAIL same_cycle_drop got v=%0b instr=%h exp v=0 instr=%h", instr_valid, instruction, NOP); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin errors++; $display("FAIL same_cycle_next got req=%0b addr=%h exp req=1 addr=00000400", imem_req, imem_addr); end
  endtask

  task automatic test_fault();
    instr_ready = 1'b0;
    imem_ready = 1'b1; imem_rdata = 32'h0000_0055;
    tick();
    imem_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h202;
    tick();
    redirect_valid = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fault_squash got %0b exp 0", instr_valid); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (fetch_fault !== 1'b1 || imem_req !== 1'b0 || imem_addr !== 32'h200) begin
        errors++; $display("FAIL fault_idle%0d got f=%0b req=%0b addr=%h exp f=1 req=0 addr=00000200", i, fetch_fault, imem_req, imem_addr);
      end
      tick();
    end
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect_valid = 1'b0;
    checks++; if (fetch_fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
      errors++; $display("FAIL fault_clear got f=%0b req=%0b addr=%h exp f=0 req=1 addr=00000300", fetch_fault, imem_req, imem_addr);
    end
    // misaligned redirect while a request is outstanding drains it first
    redirect_valid = 1'b1; redirect_pc = 32'h305;
    tick();
    redirect_valid = 1'b0;
    checks++; if (fetch_fault !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
      errors++; $display("FAIL fault_discard got f=%0b req=%0b addr=%h exp f=1 req=1 addr=00000300", fetch_fault, imem_req, imem_addr);
    end
    imem_ready = 1'b1; imem_rdata = 32'h7777_7777;
    tick();
    imem_ready = 1'b0;
    checks++; if (fetch_fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 32'h304) begin
      errors++; $display("FAIL fault_after_discard got f=%0b req=%0b v=%0b addr=%h exp f=1 req=0 v=0 addr=00000304", fetch_fault, imem_req, instr_valid, imem_addr);
    end
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    checks++; if (fetch_fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL fault_to_top got f=%0b req=%0b addr=%h exp f=0 req=1 addr=fffffffc", fetch_fault, imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap();
    instr_ready = 1'b1;
    imem_ready = 1'b1; imem_rdata = 32'hCAFE_F00D;
    tick();
    imem_ready = 1'b0;
    checks++; if (instr_valid !== 1'b1 || pc_out !== 32'hFFFF_FFFC || instruction !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL wrap_capture got v=%0b pc=%h instr=%h exp v=1 pc=fffffffc instr=cafef00d", instr_valid, pc_out, instruction);
    end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next got req=%0b addr=%h exp req=1 addr=00000000", imem_req, imem_addr); end
  endtask

  task automatic test_reset_mid_request();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h100) begin errors++; $display("FAIL async_reset got req=%0b addr=%h exp req=0 addr=00000100", imem_req, imem_addr); end
    tick();
    rst_n = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h800;
    tick();
    redirect_valid = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || fetch_fault !== 1'b0) begin
      errors++; $display("FAIL boot_redirect_ignored got req=%0b addr=%h f=%0b exp req=1 addr=00000100 f=0", imem_req, imem_addr, fetch_fault);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_hold();
    test_redirect_outstanding();
    test_redirect_same_cycle();
    test_fault();
    test_wrap();
    test_reset_mid_request();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
